// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// EX operand forward selects, the hard-wired zero register and match helpers.
package pipe_hazard_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_MEM_ERR  = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register 0 is constant, so it can never be the subject of a RAW dependency.
  function automatic logic src_hit(input logic [4:0] src, input logic used,
                                   input logic [4:0] dst, input logic wr);
    return used && wr && (src == dst) && (src != REG_ZERO);
  endfunction

  // The younger producer (MEM) holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                          input logic [4:0] mem_dst, input logic mem_wr,
                                          input logic [4:0] wb_dst, input logic wb_wr);
    if (src_hit(src, 1'b1, mem_dst, mem_wr)) return FWD_MEM;
    if (src_hit(src, 1'b1, wb_dst, wb_wr)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW match and operand-forward selection for the ID instruction.
// PIPE_FORWARD_EN selects forwarding (only loads stall); otherwise every writer stalls.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_regaddr,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_regaddr,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_regaddr,
  input  logic       wb_regwrite,
  output logic       hazard,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

`ifdef PIPE_FORWARD_EN
  assign ex_hit  = src_hit(id_rs, id_use_rs, ex_regaddr, ex_memread) ||
                   src_hit(id_rt, id_use_rt, ex_regaddr, ex_memread);
  assign mem_hit = 1'b0;
  assign wb_hit  = 1'b0;
  assign fwd_a   = fwd_pick(id_rs, mem_regaddr, mem_regwrite, wb_regaddr, wb_regwrite);
  assign fwd_b   = fwd_pick(id_rt, mem_regaddr, mem_regwrite, wb_regaddr, wb_regwrite);
`else
  // A load in EX writes its destination too, even if regwrite is not flagged.
  logic ex_wr;
  assign ex_wr   = ex_regwrite || ex_memread;
  assign ex_hit  = src_hit(id_rs, id_use_rs, ex_regaddr, ex_wr) ||
                   src_hit(id_rt, id_use_rt, ex_regaddr, ex_wr);
  assign mem_hit = src_hit(id_rs, id_use_rs, mem_regaddr, mem_regwrite) ||
                   src_hit(id_rt, id_use_rt, mem_regaddr, mem_regwrite);
  assign wb_hit  = src_hit(id_rs, id_use_rs, wb_regaddr, wb_regwrite) ||
                   src_hit(id_rt, id_use_rt, wb_regaddr, wb_regwrite);
  assign fwd_a   = FWD_RF;
  assign fwd_b   = FWD_RF;
`endif

  assign hazard = ex_hit || mem_hit || wb_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: dmem wait/timeout FSM, branch flush, RAW stall, stall counter.
// Optional operand forwarding is enabled by defining PIPE_FORWARD_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_regaddr,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_regaddr,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_regaddr,
  input  logic             wb_regwrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if2id_we,
  output logic             id2ex_we,
  output logic             ex2mem_we,
  output logic             if2id_flush,
  output logic             id2ex_flush,
  output logic             mem2wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The RUN cycle that starts a wait is the first not-ready cycle, so the
  // counter only has to cover the remaining TIMEOUT_CYCLES-1 inside MEM_WAIT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 2);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              frozen;
  logic              branch;
  logic              stall;

  hazard_detect u_hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_regaddr   (ex_regaddr),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_regaddr  (mem_regaddr),
    .mem_regwrite (mem_regwrite),
    .wb_regaddr   (wb_regaddr),
    .wb_regwrite  (wb_regwrite),
    .hazard       (hazard),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always_comb begin
    frozen    = 1'b0;
    state_nxt = state;
    case (state)
      ST_RUN: begin
        frozen = dmem_req && !dmem_ready;
        if (frozen) state_nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        frozen = !dmem_ready;
        if (dmem_ready)                  state_nxt = ST_RUN;
        else if (wait_cnt == WAIT_LAST)  state_nxt = ST_MEM_ERR;
      end
      default: begin
        frozen    = 1'b1;
        state_nxt = ST_MEM_ERR;
      end
    endcase
  end

  // A frozen MEM stage outranks everything; a taken branch outranks a RAW stall.
  assign branch       = !frozen && ex_branch_taken;
  assign stall        = !frozen && !ex_branch_taken && hazard;
  assign pc_we        = !frozen && !stall;
  assign if2id_we     = !frozen && !stall;
  assign id2ex_we     = !frozen;
  assign ex2mem_we    = !frozen;
  assign if2id_flush  = branch;
  assign id2ex_flush  = branch || stall;
  assign mem2wb_flush = frozen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= (state == ST_MEM_WAIT && !dmem_ready) ? wait_cnt + 1'b1 : '0;
      mem_timeout <= mem_timeout || (state_nxt == ST_MEM_ERR);
      if (!pc_we && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks plus randomized
// stimulus against a behavioural model; honours PIPE_FORWARD_EN like the design.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CW      = 6;
  localparam longint SAT = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_regaddr, mem_regaddr, wb_regaddr;
  logic          id_use_rs, id_use_rt, ex_regwrite, ex_memread;
  logic          mem_regwrite, wb_regwrite, ex_branch_taken, dmem_req, dmem_ready;
  logic          pc_we, if2id_we, id2ex_we, ex2mem_we;
  logic          if2id_flush, id2ex_flush, mem2wb_flush, mem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int     n_cmp = 0;
  int     n_bad = 0;
  bit     armed = 1'b0;
  bit     m_err, m_wait;
  int     m_nr;
  longint m_stall;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_regaddr(ex_regaddr), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_regaddr(mem_regaddr), .mem_regwrite(mem_regwrite),
    .wb_regaddr(wb_regaddr), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if2id_we(if2id_we), .id2ex_we(id2ex_we), .ex2mem_we(ex2mem_we),
    .if2id_flush(if2id_flush), .id2ex_flush(id2ex_flush), .mem2wb_flush(mem2wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_frozen();
    return m_err || ((m_wait || dmem_req) && !dmem_ready);
  endfunction

  function automatic bit model_hazard();
    logic [4:0] src[2];
    logic       rd[2];
    logic [4:0] dst[3];
    logic       wr[3];
    src[0] = id_rs;      src[1] = id_rt;
    rd[0]  = id_use_rs;  rd[1]  = id_use_rt;
    dst[0] = ex_regaddr; dst[1] = mem_regaddr; dst[2] = wb_regaddr;
`ifdef PIPE_FORWARD_EN
    wr[0] = ex_memread; wr[1] = 1'b0; wr[2] = 1'b0;
`else
    wr[0] = ex_regwrite | ex_memread; wr[1] = mem_regwrite; wr[2] = wb_regwrite;
`endif
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 3; w++)
        if (rd[s] && wr[w] && src[s] != 5'd0 && src[s] == dst[w]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] s);
    logic [1:0] r;
    r = 2'b00;
`ifdef PIPE_FORWARD_EN
    if (mem_regwrite && mem_regaddr == s)     r = 2'b01;
    else if (wb_regwrite && wb_regaddr == s)  r = 2'b10;
`endif
    return (s == 5'd0) ? 2'b00 : r;
  endfunction

  function automatic bit model_stall();
    return !model_frozen() && !ex_branch_taken && model_hazard();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_err = 1'b0; m_wait = 1'b0; m_nr = 0; m_stall = 0;
    end else begin
      if ((model_frozen() || model_stall()) && m_stall < SAT) m_stall++;
      if (!m_err) begin
        if (model_frozen()) begin
          m_nr++;
          if (m_nr >= TIMEOUT) begin m_err = 1'b1; m_wait = 1'b0; end
          else m_wait = 1'b1;
        end else begin
          m_nr = 0; m_wait = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && armed) begin
      bit fz, br, st;
      fz = model_frozen();
      br = !fz && ex_branch_taken;
      st = model_stall();
      chk("pc_we",        pc_we,        !fz && !st);
      chk("if2id_we",     if2id_we,     !fz && !st);
      chk("id2ex_we",     id2ex_we,     !fz);
      chk("ex2mem_we",    ex2mem_we,    !fz);
      chk("if2id_flush",  if2id_flush,  br);
      chk("id2ex_flush",  id2ex_flush,  br || st);
      chk("mem2wb_flush", mem2wb_flush, fz);
      chk("fwd_a",        fwd_a,        model_fwd(id_rs));
      chk("fwd_b",        fwd_b,        model_fwd(id_rt));
      chk("mem_timeout",  mem_timeout,  m_err);
      chk("stall_cnt",    stall_cnt,    m_stall);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_regaddr = 0; ex_regwrite = 0; ex_memread = 0;
    mem_regaddr = 0; mem_regwrite = 0; wb_regaddr = 0; wb_regwrite = 0;
    ex_branch_taken = 0; dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next();
    reset = 1'b0;
  endtask

  int prs[3] = '{90, 50, 3};

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    armed = 1'b1;

    // reset state with idle inputs
    #2;
    chk("rst_pc_we", pc_we, 1); chk("rst_id2ex_we", id2ex_we, 1);
    chk("rst_if2id_flush", if2id_flush, 0); chk("rst_mem2wb_flush", mem2wb_flush, 0);
    chk("rst_fwd_a", fwd_a, 0); chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall_cnt", stall_cnt, 0); chk("rst_mem_timeout", mem_timeout, 0);

    // load-use on rs
    next(); ex_memread = 1; ex_regaddr = 5; id_rs = 5; id_use_rs = 1; #2;
    chk("lu_pc_we", pc_we, 0); chk("lu_if2id_we", if2id_we, 0);
    chk("lu_id2ex_flush", id2ex_flush, 1); chk("lu_id2ex_we", id2ex_we, 1);
    chk("lu_if2id_flush", if2id_flush, 0);
    next(); idle(); #2;
    chk("lu_release_pc_we", pc_we, 1); chk("lu_stall_cnt", stall_cnt, 1);

    // branch beats load-use
    next(); ex_memread = 1; ex_regaddr = 5; id_rs = 5; id_use_rs = 1; ex_branch_taken = 1; #2;
    chk("br_if2id_flush", if2id_flush, 1); chk("br_id2ex_flush", id2ex_flush, 1);
    chk("br_pc_we", pc_we, 1); chk("br_if2id_we", if2id_we, 1);
    next(); idle(); #2;
    chk("br_stall_cnt", stall_cnt, 1);

    // register 0 never hazards or forwards
    next(); ex_memread = 1; ex_regaddr = 0; id_rs = 0; id_use_rs = 1;
    mem_regaddr = 0; mem_regwrite = 1; #2;
    chk("r0_pc_we", pc_we, 1); chk("r0_fwd_a", fwd_a, 0);

`ifdef PIPE_FORWARD_EN
    next(); idle(); mem_regaddr = 3; mem_regwrite = 1; wb_regaddr = 3; wb_regwrite = 1;
    id_rs = 3; id_use_rs = 1; #2;
    chk("fw_mem_fwd_a", fwd_a, 1); chk("fw_pc_we", pc_we, 1);
    next(); mem_regwrite = 0; #2;
    chk("fw_wb_fwd_a", fwd_a, 2);
    next(); idle(); #2;
    chk("fw_stall_cnt", stall_cnt, 1);
`else
    next(); idle(); wb_regaddr = 7; wb_regwrite = 1; id_rt = 7; id_use_rt = 1; #2;
    for (int i = 0; i < 3; i++) begin
      chk("raw_wb_pc_we", pc_we, 0); chk("raw_wb_fwd_b", fwd_b, 0);
      if (i < 2) begin next(); #2; end
    end
    next(); wb_regwrite = 0; #2;
    chk("raw_clear_pc_we", pc_we, 1);
    next(); idle(); #2;
    chk("raw_stall_cnt", stall_cnt, 4);
`endif

    // dmem wait of four not-ready cycles; branch held during the wait
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next();
      dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1; #2;
      chk("wait_pc_we", pc_we, 0); chk("wait_mem2wb_flush", mem2wb_flush, 1);
      chk("wait_ex2mem_we", ex2mem_we, 0); chk("wait_if2id_flush", if2id_flush, 0);
    end
    next(); dmem_ready = 1; ex_branch_taken = 0; #2;
    chk("ready_pc_we", pc_we, 1); chk("ready_mem2wb_flush", mem2wb_flush, 0);
    next(); idle(); ex_branch_taken = 1; #2;
    chk("post_wait_pc_we", pc_we, 1); chk("post_wait_if2id_flush", if2id_flush, 1);
    chk("wait_stall_cnt", stall_cnt, 4);

    // 15 not-ready cycles is one short of the timeout
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next();
      dmem_req = 1; dmem_ready = 0;
    end
    next(); dmem_ready = 1;
    next(); idle(); #2;
    chk("t15_mem_timeout", mem_timeout, 0); chk("t15_pc_we", pc_we, 1);
    chk("t15_stall_cnt", stall_cnt, 15);

    // 16 not-ready cycles reaches MEM_ERR, which only reset clears
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) next();
      dmem_req = 1; dmem_ready = 0;
    end
    #2;
    chk("t16_last_mem_timeout", mem_timeout, 0);
    next(); idle(); #2;
    chk("err_mem_timeout", mem_timeout, 1); chk("err_pc_we", pc_we, 0);
    chk("err_mem2wb_flush", mem2wb_flush, 1);
    repeat (3) next();
    #2;
    chk("err_sticky", mem_timeout, 1); chk("err_id2ex_we", id2ex_we, 0);
    reset = 1'b1; #1;
    chk("async_rst_mem_timeout", mem_timeout, 0); chk("async_rst_pc_we", pc_we, 1);
    next(); reset = 1'b0;

    // randomized phase, varying memory readiness per segment
    for (int seg = 0; seg < 12; seg++) begin
      for (int c = 0; c < 200; c++) begin
        next();
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        ex_regaddr = 5'($urandom_range(0, 3)); ex_regwrite = 1'($urandom);
        ex_memread = ($urandom_range(0, 3) == 0);
        mem_regaddr = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom);
        wb_regaddr = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
        ex_branch_taken = ($urandom_range(0, 7) == 0);
        dmem_req = ($urandom_range(0, 3) == 0);
        dmem_ready = ($urandom_range(0, 99) < prs[seg % 3]);
      end
      do_reset();
    end

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max dmem wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs, id_rt  in  5  ID-stage source register addresses.
REQ-006 SHALL have ports id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt.
REQ-007 SHALL have ports ex_regaddr  in  5, ex_regwrite  in  1, ex_memread  in  1  ID2EX contents.
REQ-008 SHALL have ports mem_regaddr  in  5, mem_regwrite  in  1  EX2MEM contents.
REQ-009 SHALL have ports wb_regaddr  in  5, wb_regwrite  in  1  MEM2WB contents.
REQ-010 SHALL have port ex_branch_taken  in  1  EX resolves a taken branch/jump.
REQ-011 SHALL have ports dmem_req  in  1, dmem_ready  in  1  MEM-stage data memory handshake.
REQ-012 SHALL have outputs pc_we, if2id_we, id2ex_we, ex2mem_we  out  1  register enables.
REQ-013 SHALL have outputs if2id_flush, id2ex_flush, mem2wb_flush  out  1  bubble inserts.
REQ-014 SHALL have outputs fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM, 10 WB.
REQ-015 SHALL have outputs mem_timeout  out  1 sticky error; stall_cnt  out  CNT_W stall cycles.

Function
REQ-016 SHALL run FSM states RUN, MEM_WAIT, MEM_ERR.
REQ-017 RUN -> MEM_WAIT when dmem_req=1 and dmem_ready=0; dmem_req=1 with dmem_ready=1 stays RUN, no stall.
REQ-018 In MEM_WAIT: pc_we, if2id_we, id2ex_we, ex2mem_we =0; mem2wb_flush=1; other flushes=0.
REQ-019 MEM_WAIT -> RUN in the cycle after dmem_ready=1; enables return to 1 that same ready cycle.
REQ-020 Wait counter SHALL reset on MEM_WAIT entry; at TIMEOUT_CYCLES consecutive not-ready cycles -> MEM_ERR.
REQ-021 MEM_ERR SHALL hold all enables 0, mem2wb_flush=1, mem_timeout=1 until reset.
REQ-022 In RUN, ex_branch_taken=1 SHALL assert if2id_flush=1 and id2ex_flush=1 for that cycle; enables stay 1.
REQ-023 In RUN, load-use stall when ex_memread=1, ex_regaddr!=0, and matches id_rs (id_use_rs) or id_rt (id_use_rt): pc_we=0, if2id_we=0, id2ex_flush=1.
REQ-024 Priority: MEM_WAIT/MEM_ERR > branch flush > load-use stall; branch during wait SHALL take effect on the first RUN cycle.
REQ-025 Register 0 SHALL never produce a hazard or a forward.
REQ-026 stall_cnt SHALL increment once per cycle with any of pc_we=0 or id2ex_flush=1 due to stall, saturating at all-ones.
REQ-027 All outputs except stall_cnt, mem_timeout and the FSM SHALL be combinational from inputs and state.

Reset
REQ-028 Reset SHALL force state RUN, wait counter 0, stall_cnt 0, mem_timeout 0.
REQ-029 After reset, with idle inputs, enables=1, flushes=0, fwd_a=fwd_b=00.
REQ-030 Reset during MEM_WAIT or MEM_ERR SHALL return to RUN immediately, asynchronously.

Configuration
REQ-031 Macro PIPE_FORWARD_EN defined: fwd_a/fwd_b SHALL select MEM (01) over WB (10) on address match with regwrite=1; load-use stall per REQ-023 is 1 cycle.
REQ-032 Macro PIPE_FORWARD_EN undefined: fwd_a=fwd_b=00 always; RAW hazard against any of EX, MEM, WB writer SHALL stall per REQ-023 mechanics until no match remains.

Structure
REQ-033 Shared package SHALL hold FSM state enum, fwd select constants FWD_RF/FWD_MEM/FWD_WB, register-0 constant.
REQ-034 Sub-module hazard_detect SHALL hold combinational match/forward logic; FSM, counters in top.

Verification
REQ-035 ex_memread=1, ex_regaddr=5, id_rs=5, id_use_rs=1 -> one cycle pc_we=0, if2id_we=0, id2ex_flush=1; stall_cnt +1.
REQ-036 mem_regaddr=3 regwrite, wb_regaddr=3 regwrite, id_rs=3 in EX (forwarding on) -> fwd_a=01; ex regaddr 0 -> fwd_a=00.
REQ-037 dmem_req=1, dmem_ready low 4 cycles then high -> 4 frozen cycles with mem2wb_flush=1, RUN next; stall_cnt +4.
REQ-038 dmem_ready held low 16 cycles -> MEM_ERR, mem_timeout=1 sticky; reset pulse -> RUN, mem_timeout=0.
REQ-039 ex_branch_taken=1 concurrent with load-use match -> if2id_flush=1, id2ex_flush=1, pc_we=1.
REQ-040 Without PIPE_FORWARD_EN, wb_regaddr=7 regwrite, id_rt=7 used -> stall until WB clears; fwd_b=00.
